// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
//   Handshake bundle for pipe_skid_reg: upstream valid/ready/data,
//   downstream valid/ready/data, a synchronous flush request and the
//   live-entry count.
//   slave  : the skid register's view (drives in_ready/out_*/occupancy)
//   master : the surrounding logic's view (drives flush/in_*/out_ready)
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry skid register that breaks the ready path between a producer
//   and a consumer while keeping full throughput. The main entry drives the
//   output; the skid entry catches the one payload that arrives while the
//   consumer stalls. in_ready comes straight from a flop, so out_ready never
//   reaches the upstream side combinationally.
// Ports
//   clk : clock, rising edge
//   rst : synchronous active-high reset (wins over flush)
//   bus : pipe_skid_reg_if.slave
//         flush     - drop every held and incoming payload this cycle
//         in_valid  / in_ready / in_data   - upstream handshake
//         out_valid / out_ready / out_data - downstream handshake
//         occupancy - live entries, 0..2
// Parameters
//   WIDTH     : payload width (1..256); must match the interface WIDTH
//   NOP_VALUE : value shown on out_data while out_valid=0
module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input logic             clk,
  input logic             rst,
  pipe_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_main_valid;
  logic             r_skid_valid;
  logic             r_in_ready;
  logic [1:0]       r_occupancy;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic             w_accept;
  logic             w_transfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_transfer = r_main_valid & bus.out_ready;

  // Next state and payload write enables. Flush suppresses every load; the
  // stale payload registers are harmless because the output is masked by
  // the valid bits.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (bus.flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_next   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_transfer) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_state_next = ST_FULL;
          end else if (w_transfer) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (w_transfer) begin
            w_load_main_skid = 1'b1;
            w_state_next     = ST_ONE;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // State plus the flags that leave the block; all are decoded from the
  // next state so the outputs are plain flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_occupancy  <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_main_valid <= (w_state_next != ST_EMPTY);
      r_skid_valid <= (w_state_next == ST_FULL);
      r_in_ready   <= (w_state_next != ST_FULL);
      case (w_state_next)
        ST_ONE:  r_occupancy <= 2'd1;
        ST_FULL: r_occupancy <= 2'd2;
        default: r_occupancy <= 2'd0;
      endcase
    end
  end

  // Payload storage: write-enable only, no reset.
  always_ff @(posedge clk) begin
    if (w_load_main_in) begin
      r_main_data <= bus.in_data;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
    end
    if (w_load_skid) begin
      r_skid_data <= bus.in_data;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_valid ? r_main_data : NOP_VALUE;
  assign bus.occupancy = r_occupancy;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 The block SHALL have parameter NOP_VALUE, default all-zero WIDTH bits: value driven on out_data while out_valid=0.
REQ-003 The block SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1: synchronous discard of all held and incoming payloads.
REQ-006 The block SHALL have port in_valid, input, 1: upstream offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1: block can accept this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1: out_data holds a live payload.
REQ-010 The block SHALL have port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH: downstream payload.
REQ-012 The block SHALL have port occupancy, output, 2: number of live entries, 0..2.

Function
REQ-013 Storage SHALL be two entries: main (drives out_data) and skid; each entry carries a valid bit.
REQ-014 in_ready SHALL equal NOT skid_valid, driven directly from a flop with no combinational path from out_ready.
REQ-015 Accept SHALL be in_valid AND in_ready; transfer SHALL be out_valid AND out_ready; both evaluated in the same cycle.
REQ-016 out_valid SHALL equal main_valid.
REQ-017 out_data SHALL equal main payload when main_valid=1, else NOP_VALUE.
REQ-018 The states SHALL be EMPTY (0 entries), ONE (main only), and FULL (main+skid); skid-only SHALL be unreachable.
REQ-019 In EMPTY, accept SHALL load main and go to ONE; latency from in to out SHALL be 1 cycle.
REQ-020 In ONE, accept with transfer SHALL load main and stay in ONE, giving full throughput.
REQ-021 In ONE, accept without transfer SHALL load skid and go to FULL.
REQ-022 In ONE, transfer without accept SHALL go to EMPTY.
REQ-023 In FULL, transfer SHALL move skid into main and go to ONE; no accept is possible because in_ready=0.
REQ-024 In FULL with no transfer, state SHALL hold.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL stay bit-stable.
REQ-026 Payload order SHALL be preserved: strict FIFO, with no loss or duplication.
REQ-027 When flush=1, the next state SHALL be EMPTY and main_valid and skid_valid SHALL clear.
REQ-028 A payload accepted in the flush cycle SHALL be discarded.
REQ-029 A transfer in the flush cycle SHALL still count as consumed by downstream, since out_valid was 1 that cycle.
REQ-030 Priority SHALL be rst > flush > normal operation.
REQ-031 occupancy SHALL equal main_valid + skid_valid, registered, and SHALL be consistent with in_ready and out_valid every cycle.
REQ-032 Payload registers SHALL load only on a write enable; they SHALL NOT be required to clear on flush, because the output is masked by REQ-017.

Reset
REQ-033 While rst=1, on every clock: main_valid=0, skid_valid=0, out_valid=0, in_ready=1 from the cycle after the first rst edge, occupancy=0, out_data=NOP_VALUE.
REQ-034 Reset asserted mid-operation, in any state, SHALL discard all entries with no residual payload after deassertion.
REQ-035 The first accept SHALL be possible in the first cycle with rst=0.

Verification
REQ-036 Streaming (WIDTH=8, NOP_VALUE=0): in_valid=1 with data 0x01,0x02,0x03 on consecutive cycles, out_ready=1 -> out_data is 0x01,0x02,0x03 one cycle later each; in_ready stays 1; occupancy stays 1.
REQ-037 Backpressure: send 0xA1 then 0xA2 with out_ready=0 -> occupancy=2, in_ready=0, and out_data holds 0xA1 for 5 cycles; after out_ready=1 -> 0xA1 then 0xA2, then out_valid=0 and out_data=0x00.
REQ-038 Simultaneous accept and transfer in ONE: main=0x10 with in_data=0x11 and out_ready=1 -> next out_data=0x11, occupancy=1.
REQ-039 Flush while FULL (0x20,0x21) with in_valid=1 carrying 0x22 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x22 never appears at the output.
REQ-040 Reset mid-stream while FULL -> after rst deasserts, out_valid=0, in_ready=1, and the next output is the first post-reset input.
REQ-041 Random stimulus for 10k cycles with a scoreboard -> output sequence equals accepted-input sequence minus flushed entries, and no in_ready/occupancy mismatch occurs.
